// File: rtl/uart_frame_parser.sv
// uart_frame_parser: receive-side UART frame parser.
// Frame layout: SOF, LEN, LEN payload bytes, CHK. CHK is the XOR of LEN and all payload bytes.
// The payload is buffered and sent downstream on a valid/ready stream only after CHK matches.
// Define UART_FRAME_TIMEOUT_EN to abort a frame that stalls for TIMEOUT_CYCLES between bytes.
module uart_frame_parser #(
    parameter int         MAX_LEN        = 64,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       drop,
    output logic       busy
);

    localparam int         PW        = $clog2(MAX_LEN + 1);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_LINE = 2'd3;

    // LEN travels as one byte, so the buffer can never need more than 255 entries.
    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    state_t        state_reg;
    logic [PW-1:0] len_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [7:0]    xor_reg;
    logic [7:0]    out_data_reg;
    logic          out_valid_reg;
    logic          out_last_reg;
    logic          frame_ok_reg;
    logic          frame_err_reg;
    logic [1:0]    err_code_reg;
    logic          drop_reg;

    logic [7:0]    buf_mem [0:MAX_LEN-1];

    logic          buf_we;
    logic          len_bad;
    logic          in_frame;
    logic          timeout_hit;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;

    assign in_frame    = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) || (state_reg == ST_CHK);
    assign buf_we      = (state_reg == ST_PAYLOAD) && rx_valid && !rx_error;
    // LEN is judged on the full received byte, before it is narrowed to the counter width.
    assign len_bad     = (rx_data == 8'd0) || ({1'b0, rx_data} > MAX_LEN_W);
    assign wr_ptr_next = wr_ptr_reg + PW'(1);
    assign rd_ptr_next = rd_ptr_reg + PW'(1);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_reg;

    assign timeout_hit = in_frame && !rx_valid && !rx_error &&
                         (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    // Inter-byte silence counter; only counts while a frame is being received.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_reg <= '0;
        end else if (!in_frame || rx_valid || timeout_hit) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Payload buffer write port; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_ptr_reg[AW-1:0]] <= rx_data;
        end
    end

    // Frame FSM: parse, verify checksum, then drain the buffer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            xor_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= '0;
            drop_reg      <= 1'b0;
        end else begin
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            drop_reg      <= 1'b0;

            if (in_frame && (rx_error || timeout_hit)) begin
                // A line error beats any byte arriving in the same cycle.
                frame_err_reg <= 1'b1;
                err_code_reg  <= ERR_LINE;
                wr_ptr_reg    <= '0;
                state_reg     <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rx_valid && rx_data == SOF_BYTE) begin
                            state_reg <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            len_reg    <= PW'(rx_data);
                            xor_reg    <= rx_data;
                            wr_ptr_reg <= '0;
                            if (len_bad) begin
                                frame_err_reg <= 1'b1;
                                err_code_reg  <= ERR_LEN;
                                state_reg     <= ST_IDLE;
                            end else begin
                                state_reg <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_valid) begin
                            xor_reg    <= xor_reg ^ rx_data;
                            wr_ptr_reg <= wr_ptr_next;
                            if (wr_ptr_next == len_reg) begin
                                state_reg <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (rx_valid) begin
                            if (rx_data == xor_reg) begin
                                frame_ok_reg <= 1'b1;
                                rd_ptr_reg   <= '0;
                                state_reg    <= ST_DRAIN;
                            end else begin
                                frame_err_reg <= 1'b1;
                                err_code_reg  <= ERR_CHK;
                                wr_ptr_reg    <= '0;
                                state_reg     <= ST_IDLE;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Bytes arriving while draining are never parsed.
                        drop_reg <= rx_valid;
                        if (!out_valid_reg) begin
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= buf_mem[rd_ptr_reg[AW-1:0]];
                            out_last_reg  <= (rd_ptr_reg == len_reg - PW'(1));
                        end else if (out_ready) begin
                            if (out_last_reg) begin
                                out_valid_reg <= 1'b0;
                                out_last_reg  <= 1'b0;
                                rd_ptr_reg    <= '0;
                                wr_ptr_reg    <= '0;
                                state_reg     <= ST_IDLE;
                            end else begin
                                rd_ptr_reg   <= rd_ptr_next;
                                out_data_reg <= buf_mem[rd_ptr_next[AW-1:0]];
                                out_last_reg <= (rd_ptr_next == len_reg - PW'(1));
                            end
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign frame_ok  = frame_ok_reg;
    assign frame_err = frame_err_reg;
    assign err_code  = err_code_reg;
    assign drop      = drop_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Byte-stream frame parser on the receive side of the UART.
- Consumes the received byte stream (rx_data/rx_valid/rx_error) and checks framing, length and checksum.
- Buffers the payload. Releases a frame downstream on a valid/ready stream only after the checksum passes.
- Frame format: SOF, LEN, LEN payload bytes, CHK. CHK is the XOR of LEN and all payload bytes.

Parameters:
- MAX_LEN, 64: maximum payload length in bytes; also the buffer depth.
- SOF_BYTE, 8'hA5: start-of-frame marker.
- TIMEOUT_CYCLES, 50000: inter-byte timeout in clk cycles. Used only with UART_FRAME_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data valid
- rx_error  input  1  one-cycle strobe; line/parity/framing error on current byte
- out_data  output  8  payload byte
- out_valid  output  1  payload byte available
- out_ready  input  1  downstream accepts byte
- out_last  output  1  marks the final payload byte of a frame
- frame_ok  output  1  one-cycle pulse; frame passed checks; drain begins next cycle
- frame_err  output  1  one-cycle pulse; frame discarded
- err_code  output  2  cause of last error: 0 none, 1 bad LEN, 2 CHK mismatch, 3 line error/timeout; held until next error
- drop  output  1  one-cycle pulse; byte arrived during DRAIN and was discarded
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous and active-high on `reset`.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Length counter, write/read pointers and running XOR are 0.
- State IDLE:
  - Bytes other than SOF_BYTE are ignored silently.
  - rx_error is ignored.
  - rx_valid with SOF_BYTE moves to LEN.
- State LEN (on rx_valid):
  - Store LEN and set XOR = LEN.
  - LEN == 0 or LEN > MAX_LEN: frame_err=1, err_code=1, go to IDLE.
  - Otherwise go to PAYLOAD.
- State PAYLOAD (on rx_valid):
  - Write byte to buffer[wr_ptr] and XOR it into the running checksum.
  - Go to CHK after the LEN-th byte.
- State CHK (on rx_valid):
  - byte == XOR: frame_ok=1 and go to DRAIN.
  - Otherwise: frame_err=1, err_code=2, go to IDLE. The buffer is discarded by pointer reset.
- rx_error in LEN, PAYLOAD or CHK:
  - frame_err=1, err_code=3, go to IDLE.
  - rx_error takes priority over a simultaneous rx_valid.
- State DRAIN:
  - out_valid=1 and out_data=buffer[rd_ptr].
  - out_data is registered and stable while out_valid && !out_ready.
  - Each accepted transfer (out_valid && out_ready) advances rd_ptr.
  - out_last=1 when rd_ptr == LEN-1.
  - Accepting the last byte returns to IDLE; out_valid falls the next cycle.
  - Max throughput is one byte per cycle.
- rx_valid during DRAIN: the byte is dropped and drop=1 for that cycle, including a SOF_BYTE. Bytes are never parsed while draining.
- Latency: frame_ok asserts one cycle after the CHK byte's rx_valid; the first out_valid follows one cycle later.
- Counter widths: len/ptr are $clog2(MAX_LEN+1) bits. LEN is compared at full 8-bit width before truncation.
- rx_valid and rx_error are guaranteed never to be asserted while reset is high.
- Reset mid-frame or mid-drain: immediate return to IDLE, all outputs 0, buffer contents irrelevant.
- frame_ok and frame_err are mutually exclusive and never asserted together.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- When defined:
  - A counter runs in LEN, PAYLOAD and CHK.
  - It clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES-1 with no byte: frame_err=1, err_code=3, go to IDLE.
  - The counter is held at 0 in IDLE and DRAIN.
- When undefined: no timeout logic is present, and a stalled frame waits indefinitely.

Test Plan:
- Send A5 03 11 22 33 03 with out_ready=1 -> frame_ok pulse; out_data 11,22,33 on consecutive cycles; out_last only with 33; err_code=0; busy low after the last transfer.
- Same frame, CHK=04 -> frame_err pulse, err_code=2, no out_valid, state IDLE.
- Send A5 00, then A5 41 with MAX_LEN=64 -> two frame_err pulses with err_code=1; the following A5 01 7E 7F gives frame_ok and a single byte 7E with out_last.
- Send A5 02 10, then pulse rx_error together with rx_valid -> frame_err, err_code=3; a subsequent valid frame parses normally.
- Valid 3-byte frame with out_ready toggling 1,0,0,1,0,1; inject byte A5 during DRAIN -> out_data held stable while stalled; exactly 3 transfers; drop pulses once; A5 not parsed.
- With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=20: send A5 02 11, then idle 20 cycles -> frame_err, err_code=3 on cycle 20; with the macro undefined, busy stays high.
